// File: rtl/gpu_pkg.sv
// Types and defaults shared between the frame-bus scheduler and the per-core receivers.
package gpu_pkg;

  localparam int unsigned FrameSizeDef = 16;
  localparam int unsigned FrameNumDef  = 64;
  localparam int unsigned InstrSizeDef = 16;

  typedef enum logic [1:0] {
    StIdle,
    StRecv,
    StStart,
    StRun
  } rx_state_t;

endpackage

// File: rtl/core_frame_receiver.sv
// Per-core frame-bus receiver: loads instruction beats into imem, then launches the core
// and waits for it to finish before accepting another task.
module core_frame_receiver
  import gpu_pkg::*;
#(
  parameter int unsigned CORE_ID    = 0,
  parameter int unsigned CORE_NUM   = 16,
  parameter int unsigned FRAME_SIZE = FrameSizeDef,
  parameter int unsigned FRAME_NUM  = FrameNumDef,
  parameter int unsigned INSTR_SIZE = InstrSizeDef,
  parameter int unsigned IMEM_DEPTH = 1024
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          frame_being_sent,
  input  logic [INSTR_SIZE-1:0]         bus_data,
  input  logic [CORE_NUM-1:0]           bus_core_mask,
  input  logic                          bus_last_frame,
  input  logic                          core_done,
  output logic                          core_reading,
  output logic                          core_ready,
  output logic                          imem_we,
  output logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
  output logic [INSTR_SIZE-1:0]         imem_wdata,
  output logic                          prog_start,
  output logic [$clog2(IMEM_DEPTH):0]   prog_len,
  output logic                          overflow
);

  localparam int unsigned AW = $clog2(IMEM_DEPTH);
  localparam int unsigned BW = $clog2(FRAME_SIZE);
  localparam int unsigned FW = $clog2(FRAME_NUM + 1);

  rx_state_t     state_q, state_d;
  logic [BW-1:0] beat_cnt_q, beat_cnt_d;
  logic [AW:0]   addr_cnt_q, addr_cnt_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;

  logic beat, frame_end, last_frame, full;

  assign beat       = frame_being_sent & core_reading & bus_core_mask[CORE_ID];
  assign frame_end  = beat & (beat_cnt_q == BW'(FRAME_SIZE - 1));
  // A task that reaches the frame limit is closed even without bus_last_frame.
  assign last_frame = bus_last_frame | (frame_cnt_q == FW'(FRAME_NUM - 1));
  assign full       = (addr_cnt_q == (AW + 1)'(IMEM_DEPTH));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StRecv: begin
        if (beat) state_d = (frame_end && last_frame) ? StStart : StRecv;
      end
      StStart: state_d = StRun;
      StRun:   if (core_done) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    core_ready   = (state_q == StIdle);
    core_reading = (state_q == StIdle) || (state_q == StRecv);
    prog_start   = (state_q == StStart);
  end

  always_comb begin
    beat_cnt_d  = beat_cnt_q;
    addr_cnt_d  = addr_cnt_q;
    frame_cnt_d = frame_cnt_q;
    if (beat) begin
      beat_cnt_d = frame_end ? '0 : beat_cnt_q + 1'b1;
      if (!full) addr_cnt_d = addr_cnt_q + 1'b1;
      if (frame_end && (frame_cnt_q != FW'(FRAME_NUM))) frame_cnt_d = frame_cnt_q + 1'b1;
    end
    if ((state_q == StRun) && core_done) begin
      beat_cnt_d  = '0;
      addr_cnt_d  = '0;
      frame_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      beat_cnt_q  <= '0;
      addr_cnt_q  <= '0;
      frame_cnt_q <= '0;
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= '0;
      prog_len    <= '0;
      overflow    <= 1'b0;
    end else begin
      beat_cnt_q  <= beat_cnt_d;
      addr_cnt_q  <= addr_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      imem_we     <= beat & ~full;
      if (beat && !full) begin
        imem_addr  <= addr_cnt_q[AW-1:0];
        imem_wdata <= bus_data;
      end
      if (beat && full) overflow <= 1'b1;
      // Captured on the closing beat so the length is valid alongside prog_start.
      if (frame_end && last_frame) prog_len <= addr_cnt_d;
    end
  end

  logic unused_mask;
  assign unused_mask = ^bus_core_mask;

endmodule

// File: tb/tb_core_frame_receiver.sv
// Directed bench for core_frame_receiver; a second instance with a 32-word imem covers overflow.
module tb_core_frame_receiver;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_being_sent;
  logic [15:0] bus_data;
  logic [15:0] bus_core_mask;
  logic        bus_last_frame;
  logic        core_done;

  logic        core_reading, core_ready, imem_we, prog_start, overflow;
  logic [9:0]  imem_addr;
  logic [15:0] imem_wdata;
  logic [10:0] prog_len;

  logic        s_core_reading, s_core_ready, s_imem_we, s_prog_start, s_overflow;
  logic [4:0]  s_imem_addr;
  logic [15:0] s_imem_wdata;
  logic [5:0]  s_prog_len;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  core_frame_receiver dut (
    .clk              (clk),
    .reset            (reset),
    .frame_being_sent (frame_being_sent),
    .bus_data         (bus_data),
    .bus_core_mask    (bus_core_mask),
    .bus_last_frame   (bus_last_frame),
    .core_done        (core_done),
    .core_reading     (core_reading),
    .core_ready       (core_ready),
    .imem_we          (imem_we),
    .imem_addr        (imem_addr),
    .imem_wdata       (imem_wdata),
    .prog_start       (prog_start),
    .prog_len         (prog_len),
    .overflow         (overflow)
  );

  core_frame_receiver #(.IMEM_DEPTH(32)) dut_small (
    .clk              (clk),
    .reset            (reset),
    .frame_being_sent (frame_being_sent),
    .bus_data         (bus_data),
    .bus_core_mask    (bus_core_mask),
    .bus_last_frame   (bus_last_frame),
    .core_done        (core_done),
    .core_reading     (s_core_reading),
    .core_ready       (s_core_ready),
    .imem_we          (s_imem_we),
    .imem_addr        (s_imem_addr),
    .imem_wdata       (s_imem_wdata),
    .prog_start       (s_prog_start),
    .prog_len         (s_prog_len),
    .overflow         (s_overflow)
  );

  // Write logs and event counters; tests read them relative to a saved base.
  int          cyc = 0;
  int          wr_n = 0;
  int          s_wr_n = 0;
  int          start_n = 0;
  int          s_start_n = 0;
  logic [9:0]  wr_addr [0:511];
  logic [15:0] wr_data [0:511];
  logic [4:0]  s_wr_addr [0:511];
  logic [15:0] s_wr_data [0:511];

  always @(posedge clk) begin
    cyc++;
    if (imem_we && wr_n < 512) begin
      wr_addr[wr_n] = imem_addr;
      wr_data[wr_n] = imem_wdata;
    end
    if (imem_we) wr_n++;
    if (s_imem_we && s_wr_n < 512) begin
      s_wr_addr[s_wr_n] = s_imem_addr;
      s_wr_data[s_wr_n] = s_imem_wdata;
    end
    if (s_imem_we) s_wr_n++;
    if (prog_start) start_n++;
    if (s_prog_start) s_start_n++;
  end

  task automatic send_beat(input logic [15:0] d, input logic [15:0] m, input logic l);
    frame_being_sent = 1'b1;
    bus_data         = d;
    bus_core_mask    = m;
    bus_last_frame   = l;
    @(posedge clk);
    #1;
    frame_being_sent = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_done();
    core_done = 1'b1;
    @(posedge clk);
    #1;
    core_done = 1'b0;
  endtask

  task automatic do_reset();
    reset            = 1'b1;
    frame_being_sent = 1'b0;
    core_done        = 1'b0;
    bus_last_frame   = 1'b0;
    idle_cycles(2);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset            = 1'b1;
    frame_being_sent = 1'b0;
    bus_data         = 16'h0;
    bus_core_mask    = 16'h0;
    bus_last_frame   = 1'b0;
    core_done        = 1'b0;
    idle_cycles(2);
    @(negedge clk);
    tests++; if (core_ready !== 1'b1) begin fails++; $display("FAIL reset_core_ready got %b want 1", core_ready); end
    tests++; if (core_reading !== 1'b1) begin fails++; $display("FAIL reset_core_reading got %b want 1", core_reading); end
    tests++; if (imem_we !== 1'b0) begin fails++; $display("FAIL reset_imem_we got %b want 0", imem_we); end
    tests++; if (imem_addr !== 10'd0) begin fails++; $display("FAIL reset_imem_addr got %0d want 0", imem_addr); end
    tests++; if (imem_wdata !== 16'h0) begin fails++; $display("FAIL reset_imem_wdata got %h want 0000", imem_wdata); end
    tests++; if (prog_start !== 1'b0) begin fails++; $display("FAIL reset_prog_start got %b want 0", prog_start); end
    tests++; if (prog_len !== 11'd0) begin fails++; $display("FAIL reset_prog_len got %0d want 0", prog_len); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow got %b want 0", overflow); end
    reset = 1'b0;
    idle_cycles(1);
  endtask

  task automatic test_single_frame();
    int base, sbase, bad;
    do_reset();
    base  = wr_n;
    sbase = start_n;
    for (int i = 0; i < 16; i++) send_beat(16'h1000 + 16'(i), 16'h0001, 1'b1);
    @(negedge clk);
    tests++; if (prog_start !== 1'b1) begin fails++; $display("FAIL single_prog_start got %b want 1", prog_start); end
    tests++; if (prog_len !== 11'd16) begin fails++; $display("FAIL single_prog_len got %0d want 16", prog_len); end
    tests++; if (core_reading !== 1'b0) begin fails++; $display("FAIL single_reading_drop got %b want 0", core_reading); end
    idle_cycles(4);
    @(negedge clk);
    tests++; if (start_n - sbase !== 1) begin fails++; $display("FAIL single_start_count got %0d want 1", start_n - sbase); end
    tests++; if (core_ready !== 1'b0) begin fails++; $display("FAIL single_ready_run got %b want 0", core_ready); end
    tests++; if (wr_n - base !== 16) begin fails++; $display("FAIL single_write_count got %0d want 16", wr_n - base); end
    bad = 0;
    for (int k = 0; k < 16; k++)
      if (wr_addr[base+k] !== 10'(k) || wr_data[base+k] !== 16'h1000 + 16'(k)) bad++;
    tests++; if (bad != 0) begin fails++; $display("FAIL single_write_content got %0d bad words want 0", bad); end
    pulse_done();
    @(negedge clk);
    tests++; if (core_ready !== 1'b1) begin fails++; $display("FAIL single_ready_after_done got %b want 1", core_ready); end
  endtask

  task automatic test_masked();
    int base, bad;
    do_reset();
    base = wr_n;
    bad  = 0;
    for (int i = 0; i < 32; i++) begin
      send_beat(16'hBEEF, 16'h00F0, (i >= 16) ? 1'b1 : 1'b0);
      @(negedge clk);
      if (core_ready !== 1'b1 || prog_start !== 1'b0) bad++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL masked_ready got %0d bad cycles want 0", bad); end
    idle_cycles(2);
    tests++; if (wr_n - base !== 0) begin fails++; $display("FAIL masked_writes got %0d want 0", wr_n - base); end
  endtask

  task automatic test_stall();
    int base, sbase, t0, bad;
    do_reset();
    base  = wr_n;
    sbase = start_n;
    t0    = 0;
    for (int i = 0; i < 48; i++) begin
      send_beat(16'h2000 + 16'(i), 16'h0001, (i >= 32) ? 1'b1 : 1'b0);
      if (i == 0) t0 = cyc;
      if (i == 23) idle_cycles(5);
      if (i == 46) begin
        tests++; if (start_n != sbase || prog_start !== 1'b0) begin
          fails++; $display("FAIL stall_early_start got %0d starts want 0", start_n - sbase);
        end
      end
    end
    @(negedge clk);
    tests++; if (prog_start !== 1'b1) begin fails++; $display("FAIL stall_prog_start got %b want 1", prog_start); end
    tests++; if (cyc - t0 != 52) begin fails++; $display("FAIL stall_latency got %0d want 52", cyc - t0); end
    tests++; if (prog_len !== 11'd48) begin fails++; $display("FAIL stall_prog_len got %0d want 48", prog_len); end
    idle_cycles(3);
    tests++; if (wr_n - base !== 48) begin fails++; $display("FAIL stall_write_count got %0d want 48", wr_n - base); end
    bad = 0;
    for (int k = 0; k < 48; k++)
      if (wr_addr[base+k] !== 10'(k) || wr_data[base+k] !== 16'h2000 + 16'(k)) bad++;
    tests++; if (bad != 0) begin fails++; $display("FAIL stall_write_content got %0d bad words want 0", bad); end
    pulse_done();
  endtask

  task automatic test_reset_mid();
    int base;
    do_reset();
    for (int i = 0; i < 20; i++) send_beat(16'h3300 + 16'(i), 16'h0001, 1'b0);
    reset = 1'b1;
    idle_cycles(1);
    reset = 1'b0;
    @(negedge clk);
    tests++; if (core_ready !== 1'b1) begin fails++; $display("FAIL midreset_ready got %b want 1", core_ready); end
    tests++; if (core_reading !== 1'b1) begin fails++; $display("FAIL midreset_reading got %b want 1", core_reading); end
    base = wr_n;
    for (int i = 0; i < 16; i++) send_beat(16'h3000 + 16'(i), 16'h0001, 1'b1);
    @(negedge clk);
    tests++; if (prog_len !== 11'd16) begin fails++; $display("FAIL midreset_prog_len got %0d want 16", prog_len); end
    idle_cycles(2);
    tests++; if (wr_addr[base] !== 10'd0 || wr_data[base] !== 16'h3000) begin
      fails++; $display("FAIL midreset_first_write got %0d/%h want 0/3000", wr_addr[base], wr_data[base]);
    end
    tests++; if (wr_n - base !== 16) begin fails++; $display("FAIL midreset_write_count got %0d want 16", wr_n - base); end
    pulse_done();
  endtask

  task automatic test_overflow();
    int base, sbase, bad;
    do_reset();
    base  = s_wr_n;
    sbase = s_start_n;
    for (int i = 0; i < 48; i++) begin
      send_beat(16'h4000 + 16'(i), 16'h0001, (i >= 32) ? 1'b1 : 1'b0);
      if (i == 31) begin
        @(negedge clk);
        tests++; if (s_overflow !== 1'b0) begin fails++; $display("FAIL ovf_beat32 got %b want 0", s_overflow); end
      end
      if (i == 32) begin
        @(negedge clk);
        tests++; if (s_overflow !== 1'b1 || s_imem_we !== 1'b0) begin
          fails++; $display("FAIL ovf_beat33 got ovf=%b we=%b want ovf=1 we=0", s_overflow, s_imem_we);
        end
      end
    end
    @(negedge clk);
    tests++; if (s_prog_start !== 1'b1) begin fails++; $display("FAIL ovf_prog_start got %b want 1", s_prog_start); end
    tests++; if (s_prog_len !== 6'd32) begin fails++; $display("FAIL ovf_prog_len got %0d want 32", s_prog_len); end
    idle_cycles(3);
    tests++; if (s_wr_n - base !== 32) begin fails++; $display("FAIL ovf_write_count got %0d want 32", s_wr_n - base); end
    bad = 0;
    for (int k = 0; k < 32; k++)
      if (s_wr_addr[base+k] !== 5'(k) || s_wr_data[base+k] !== 16'h4000 + 16'(k)) bad++;
    tests++; if (bad != 0) begin fails++; $display("FAIL ovf_write_content got %0d bad words want 0", bad); end
    tests++; if (s_start_n - sbase !== 1) begin fails++; $display("FAIL ovf_start_count got %0d want 1", s_start_n - sbase); end
    pulse_done();
    @(negedge clk);
    tests++; if (s_overflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky got %b want 1", s_overflow); end
  endtask

  task automatic test_done_ignore();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      core_done = (i == 5) ? 1'b1 : 1'b0;
      send_beat(16'h5000 + 16'(i), 16'h0001, 1'b1);
    end
    core_done = 1'b0;
    @(negedge clk);
    tests++; if (prog_start !== 1'b1 || prog_len !== 11'd16) begin
      fails++; $display("FAIL done_recv_ignored got start=%b len=%0d want 1/16", prog_start, prog_len);
    end
    idle_cycles(3);
    @(negedge clk);
    tests++; if (core_ready !== 1'b0) begin fails++; $display("FAIL done_run_wait got %b want 0", core_ready); end
    pulse_done();
    @(negedge clk);
    tests++; if (core_ready !== 1'b1 || core_reading !== 1'b1) begin
      fails++; $display("FAIL done_run_idle got ready=%b reading=%b want 1/1", core_ready, core_reading);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_masked();
    test_stall();
    test_reset_mid();
    test_overflow();
    test_done_ignore();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/core_frame_receiver.md
# core_frame_receiver

Core-side receiver for the scheduler's frame bus. One instance sits in front of each of the CORE_NUM compute cores. It accepts 16-bit instruction beats addressed to its core and writes them into the core's instruction memory. Once the task's last frame has landed it launches the core, and it reports idle/accepting status back to the scheduler through core_ready and core_reading.

## Interface
- CORE_ID, 0: index of this core; selects the bit of bus_core_mask that applies to this instance.
- CORE_NUM, 16: width of the destination mask.
- FRAME_SIZE, 16: beats (instructions) per frame.
- FRAME_NUM, 64: maximum number of frames per task.
- INSTR_SIZE, 16: beat and instruction width.
- IMEM_DEPTH, 1024: depth of the core instruction memory, in words.

Ports:
- clk  in  1  clock; single clock domain.
- reset  in  1  synchronous, active-high.
- frame_being_sent  in  1  scheduler beat-valid; high on every beat of a frame.
- bus_data  in  INSTR_SIZE  instruction beat.
- bus_core_mask  in  CORE_NUM  destination cores; stable for the whole frame.
- bus_last_frame  in  1  current frame is the task's final frame; stable for the whole frame.
- core_done  in  1  core finished executing the program.
- core_reading  out  1  receiver can accept a beat.
- core_ready  out  1  core idle; no program loaded or running.
- imem_we  out  1  instruction memory write enable.
- imem_addr  out  $clog2(IMEM_DEPTH)  write address.
- imem_wdata  out  INSTR_SIZE  write data.
- prog_start  out  1  one-cycle pulse that launches the core.
- prog_len  out  $clog2(IMEM_DEPTH)+1  number of instructions loaded.
- overflow  out  1  sticky flag: a beat arrived with imem full.

## Operation
- Beat accepted ("beat") on a rising clk edge when frame_being_sent && core_reading && bus_core_mask[CORE_ID].
- Frames whose mask bit for this core is 0 are ignored entirely, with no state change.

FSM states: IDLE, RECV, START, RUN.
- IDLE:
  - Outputs: core_ready=1, core_reading=1.
  - A beat writes word 0 and moves to RECV.
- RECV:
  - Outputs: core_ready=0, core_reading=1.
  - Each beat writes the next word.
  - Low frame_being_sent stalls the transfer; all counters hold.
  - On the beat where the in-frame counter reaches FRAME_SIZE-1:
    - if bus_last_frame=1, go to START;
    - otherwise the counter wraps to 0, and the state stays RECV waiting for the next frame.
- START:
  - Outputs: core_reading=0, prog_start=1 for exactly one cycle.
  - prog_len is latched from the address counter.
  - Always goes to RUN next.
- RUN:
  - Outputs: core_ready=0, core_reading=0.
  - core_done=1 returns to IDLE and clears the address counter and frame count.

Counters:
- In-frame beat counter: $clog2(FRAME_SIZE) bits, wraps.
- Address counter: one bit wider than imem_addr.
- Frame counter: saturates at FRAME_NUM. If a FRAME_NUM-th frame completes without bus_last_frame, the block treats it as the last frame and goes to START.

Overflow:
- A beat with the address counter at IMEM_DEPTH sets overflow and suppresses imem_we. Frame counting continues.
- overflow is cleared only by reset.

Other rules:
- core_done outside RUN is ignored.
- Reset in any state gives IDLE with all counters 0. Any partially written task is abandoned; nothing is rolled back in imem.

## Timing
Reset values:
- core_ready=1, core_reading=1 (decoded from IDLE).
- imem_we=0, imem_addr=0, imem_wdata=0.
- prog_start=0, prog_len=0, overflow=0.

Latencies:
- imem_we/addr/wdata are registered: the write appears on the cycle after the accepting edge.
- prog_start is asserted the cycle after the last beat is accepted. It coincides with the final imem_we, so the core must sample imem no earlier than the cycle after prog_start.
- core_reading falls in the cycle after the last beat is accepted. The scheduler must not present a new frame to this core until core_ready returns high.
- RUN→IDLE occurs on the edge where core_done=1. core_ready is high the following cycle.

Throughput:
- One beat per cycle maximum.
- A 3-frame task with no stalls occupies 3·FRAME_SIZE cycles in IDLE/RECV, plus 1 in START.

## Structure
- Shared package gpu_pkg:
  - rx_state_t enum (IDLE, RECV, START, RUN);
  - FRAME_SIZE, FRAME_NUM and INSTR_SIZE defaults, shared with the scheduler.
- Single module with one FSM and three counters; no sub-module needed.
- Instruction memory is external; this block owns only the write port.

## Test plan
- Mask 16'h0001, CORE_ID=0, 1 frame of 16 beats 0x1000..0x100F with last_frame=1:
  - imem words 0..15 hold 0x1000..0x100F;
  - prog_start pulses once the cycle after the 16th beat, with prog_len=16;
  - core_ready stays 0 until core_done.
- Mask 16'h00F0, CORE_ID=0, 2 frames:
  - no writes, state stays IDLE, core_ready=1 throughout.
- 3-frame task with frame_being_sent dropped for 5 cycles mid-frame 2:
  - 48 contiguous writes, no gaps in addresses;
  - prog_len=48; start delayed by exactly 5 cycles.
- Reset asserted after beat 20 of a 3-frame task, then a fresh 1-frame task:
  - after reset, outputs are core_ready=1, core_reading=1;
  - the new task writes from address 0, and prog_len=16.
- IMEM_DEPTH=32, 3-frame task:
  - writes to addresses 0..31, then overflow=1 at beat 33;
  - prog_len=32 and prog_start still pulses.
- core_done pulsed during RECV, then during RUN:
  - the first pulse is ignored;
  - the second returns the block to IDLE, with core_ready=1 on the next cycle.
